// File: rtl/core_pkg.sv
// Shared constants and types for the five-stage MIPS core datapath.
package core_pkg;

  // Default datapath and register-index widths.
  localparam int unsigned CORE_DW = 32;
  localparam int unsigned CORE_RW = 5;

  // Forward-select encodings used by the EX-stage operand muxes.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // ALU operation class loaded by a bubble (add).
  localparam logic [3:0] BUBBLE_ALUOP = 4'b0000;

  // Registered EX-stage control bits.
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ex_ctrl_t;

  localparam ex_ctrl_t BUBBLE_CTRL = '0;

  // True when a write-back source targets a live (non-zero) register equal to idx.
  function automatic logic fwd_match(input logic wr, input logic [CORE_RW-1:0] dst,
                                     input logic [CORE_RW-1:0] idx);
    return wr && (dst != '0) && (dst == idx);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Per-operand forwarding: picks EX/MEM, MEM/WB or the captured register value.
module fwd_unit
  import core_pkg::*;
#(
  parameter int unsigned DW = CORE_DW,
  parameter int unsigned RW = CORE_RW
) (
  input  logic [RW-1:0] i_reg_idx,
  input  logic [DW-1:0] i_reg_data,
  input  logic          i_exmem_wr,
  input  logic [RW-1:0] i_exmem_dst,
  input  logic [DW-1:0] i_exmem_result,
  input  logic          i_memwb_wr,
  input  logic [RW-1:0] i_memwb_dst,
  input  logic [DW-1:0] i_memwb_data,
  output fwd_sel_e      o_sel,
  output logic [DW-1:0] o_data
);

  logic w_hit_mem;
  logic w_hit_wb;

  // Register 0 is hardwired to zero, so a zero destination never matches.
  assign w_hit_mem = i_exmem_wr && (i_exmem_dst != '0) && (i_exmem_dst == i_reg_idx);
  assign w_hit_wb  = i_memwb_wr && (i_memwb_dst != '0) && (i_memwb_dst == i_reg_idx);

  // Select source; the younger EX/MEM result wins over MEM/WB.
  always_comb begin
    o_sel = FWD_REG;
    if (w_hit_mem) begin
      o_sel = FWD_MEM;
    end else if (w_hit_wb) begin
      o_sel = FWD_WB;
    end
  end

  // Operand mux driven by the select above.
  always_comb begin
    o_data = i_reg_data;
    case (o_sel)
      FWD_MEM: o_data = i_exmem_result;
      FWD_WB:  o_data = i_memwb_data;
      default: o_data = i_reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side forwarding, ALU operand select and
// load-use hazard detection.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int unsigned DW = CORE_DW,
  parameter int unsigned RW = CORE_RW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_dst,
  input  logic [4:0]    id_shamt,
  input  logic [DW-1:0] id_imm,
  input  logic [3:0]    id_ALUOp,
  input  logic [5:0]    id_Funct,
  input  logic          id_ALUSrc1,
  input  logic          id_ALUSrc2,
  input  logic          id_RegWrite,
  input  logic          id_MemRead,
  input  logic          id_MemWrite,
  input  logic          id_MemtoReg,
  input  logic          exmem_RegWrite,
  input  logic [RW-1:0] exmem_dst,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_RegWrite,
  input  logic [RW-1:0] memwb_dst,
  input  logic [DW-1:0] memwb_data,
  output logic [DW-1:0] ALU_In1,
  output logic [DW-1:0] ALU_In2,
  output logic [3:0]    ALU_ALUOp,
  output logic [5:0]    ALU_Funct,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dst,
  output logic          ex_valid,
  output logic          ex_RegWrite,
  output logic          ex_MemRead,
  output logic          ex_MemWrite,
  output logic          ex_MemtoReg,
  output logic          load_use
);

  ex_ctrl_t      r_ctrl;
  logic [3:0]    r_alu_op;
  logic [5:0]    r_funct;
  logic [RW-1:0] r_rs;
  logic [RW-1:0] r_rt;
  logic [RW-1:0] r_dst;
  logic [4:0]    r_shamt;
  logic [DW-1:0] r_imm;
  logic [DW-1:0] r_rs_data;
  logic [DW-1:0] r_rt_data;
  logic          r_alu_src1;
  logic          r_alu_src2;

  fwd_sel_e      w_rs_sel;
  fwd_sel_e      w_rt_sel;
  logic [DW-1:0] w_rs_fwd;
  logic [DW-1:0] w_rt_fwd;

  // Pipeline register: flush beats stall; control bits are gated by id_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl     <= BUBBLE_CTRL;
      r_alu_op   <= BUBBLE_ALUOP;
      r_funct    <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_dst      <= '0;
      r_shamt    <= '0;
      r_imm      <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_alu_src1 <= 1'b0;
      r_alu_src2 <= 1'b0;
    end else if (flush) begin
      r_ctrl     <= BUBBLE_CTRL;
      r_alu_op   <= BUBBLE_ALUOP;
      r_funct    <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_dst      <= '0;
      r_shamt    <= '0;
      r_imm      <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_alu_src1 <= 1'b0;
      r_alu_src2 <= 1'b0;
    end else if (!stall) begin
      r_ctrl.valid      <= id_valid;
      r_ctrl.reg_write  <= id_RegWrite & id_valid;
      r_ctrl.mem_read   <= id_MemRead & id_valid;
      r_ctrl.mem_write  <= id_MemWrite & id_valid;
      r_ctrl.mem_to_reg <= id_MemtoReg & id_valid;
      r_alu_op          <= id_ALUOp;
      r_funct           <= id_Funct;
      r_rs              <= id_rs;
      r_rt              <= id_rt;
      r_dst             <= id_dst;
      r_shamt           <= id_shamt;
      r_imm             <= id_imm;
      r_rs_data         <= id_rs_data;
      r_rt_data         <= id_rt_data;
      r_alu_src1        <= id_ALUSrc1;
      r_alu_src2        <= id_ALUSrc2;
    end
  end

  fwd_unit #(
    .DW (DW),
    .RW (RW)
  ) u_fwd_rs (
    .i_reg_idx      (r_rs),
    .i_reg_data     (r_rs_data),
    .i_exmem_wr     (exmem_RegWrite),
    .i_exmem_dst    (exmem_dst),
    .i_exmem_result (exmem_result),
    .i_memwb_wr     (memwb_RegWrite),
    .i_memwb_dst    (memwb_dst),
    .i_memwb_data   (memwb_data),
    .o_sel          (w_rs_sel),
    .o_data         (w_rs_fwd)
  );

  fwd_unit #(
    .DW (DW),
    .RW (RW)
  ) u_fwd_rt (
    .i_reg_idx      (r_rt),
    .i_reg_data     (r_rt_data),
    .i_exmem_wr     (exmem_RegWrite),
    .i_exmem_dst    (exmem_dst),
    .i_exmem_result (exmem_result),
    .i_memwb_wr     (memwb_RegWrite),
    .i_memwb_dst    (memwb_dst),
    .i_memwb_data   (memwb_data),
    .o_sel          (w_rt_sel),
    .o_data         (w_rt_fwd)
  );

  // Register 0 must always read the captured value; any forward on it is a bug.
  always_comb begin
    if (r_rs == '0) begin
      assert (w_rs_sel == FWD_REG);
    end
    if (r_rt == '0) begin
      assert (w_rt_sel == FWD_REG);
    end
  end

  // ALU operand select: shamt or forwarded rs, immediate or forwarded rt.
  always_comb begin
    ALU_In1       = r_alu_src1 ? {{(DW-5){1'b0}}, r_shamt} : w_rs_fwd;
    ALU_In2       = r_alu_src2 ? r_imm : w_rt_fwd;
    ex_store_data = w_rt_fwd;
  end

  assign ALU_ALUOp   = r_alu_op;
  assign ALU_Funct   = r_funct;
  assign ex_dst      = r_dst;
  assign ex_valid    = r_ctrl.valid;
  assign ex_RegWrite = r_ctrl.reg_write;
  assign ex_MemRead  = r_ctrl.mem_read;
  assign ex_MemWrite = r_ctrl.mem_write;
  assign ex_MemtoReg = r_ctrl.mem_to_reg;

  // Load in EX whose destination feeds the instruction now in ID; uses only
  // registered state and ID indices so stall/flush cannot loop back into it.
  assign load_use = r_ctrl.mem_read && (r_dst != '0) && ((r_dst == id_rs) || (r_dst == id_rt));

endmodule
